// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared width, counter width and FSM state type for the divider
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;
endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_in < divisor, so the difference always fits WIDTH+1 bits signed
  assign shifted = {rem_in, bit_in};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/div_32bit.sv
// rtl/div_32bit.sv - iterative restoring divider, one bit per cycle; DIV_SIGNED_EN selects signed operands
module div_32bit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_rem;
  logic [WIDTH-1:0] acc_quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_raw;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // acc_quo shifts the dividend out of its top while quotient bits enter at the bottom
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (acc_rem),
    .divisor (dvs),
    .bit_in  (acc_quo[WIDTH-1]),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  assign q_raw = {acc_quo[WIDTH-2:0], step_q};

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;
  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag = divisor[WIDTH-1] ? -divisor : divisor;
  assign q_fix   = neg_q ? -q_raw : q_raw;
  assign r_fix   = neg_r ? -step_rem : step_rem;
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_fix   = q_raw;
  assign r_fix   = step_rem;
`endif

  assign busy = (state == CALC);
  assign done = (state == FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc_rem     <= '0;
      acc_quo     <= '0;
      dvs         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= FIN;
            end else begin
              acc_rem     <= '0;
              acc_quo     <= dvd_mag;
              dvs         <= dvs_mag;
              cnt         <= '0;
              div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
              neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              neg_r       <= dividend[WIDTH-1];
`endif
              state       <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc_rem <= step_rem;
          acc_quo <= q_raw;
          cnt     <= cnt + 1'b1;
          // results are published only on the last step, so nothing partial leaks out
          if (cnt == LAST) begin
            quotient  <= q_fix;
            remainder <= r_fix;
            state     <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_32bit.sv
// tb/tb_div_32bit.sv - self-checking randomized bench for div_32bit against an arithmetic model
module tb_div_32bit;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;

  div_32bit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
`ifdef DIV_SIGNED_EN
      int sa;
      int sb;
      sa = a;
      sb = b;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endtask

  // Leaves the caller at the negedge of the done cycle; chain=1 launches from that FIN cycle.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b, input bit chain);
    logic [31:0] eq, er, hq, hr;
    int lat, busy_cnt;
    bit leak;
    model(a, b, eq, er);
    if (!chain) @(negedge clk);
    hq = quotient;
    hr = remainder;
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    lat = 0; busy_cnt = 0; leak = 0;
    for (int n = 1; n <= 40; n++) begin
      if (busy) begin
        busy_cnt++;
        if (quotient !== hq || remainder !== hr) leak = 1;
      end
      if (done) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_latency"}, lat, (b == 0) ? 32'd1 : 32'd33);
    check({tag, "_busy_cycles"}, busy_cnt, (b == 0) ? 32'd0 : 32'd32);
    check({tag, "_no_leak"}, {31'd0, leak}, 32'd0);
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_remainder"}, remainder, er);
    check({tag, "_div_by_zero"}, {31'd0, div_by_zero}, {31'd0, (b == 0)});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b, q0;
    int lat;
    bit seen;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;

    do_div("d100_7", 32'd100, 32'd7, 0);
    check("d100_7_q_const", quotient, 32'd14);
    check("d100_7_r_const", remainder, 32'd2);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    check("hold_quotient", quotient, 32'd14);

`ifndef DIV_SIGNED_EN
    do_div("dmax_1", 32'hFFFF_FFFF, 32'd1, 0);
    check("dmax_1_q_const", quotient, 32'hFFFF_FFFF);
`endif

    do_div("d5_0", 32'd5, 32'd0, 0);
    check("d5_0_r_const", remainder, 32'd5);
    do_div("d9_3", 32'd9, 32'd3, 0);
    check("d9_3_dbz_clear", {31'd0, div_by_zero}, 32'd0);

    // start during CALC is ignored
    @(negedge clk);
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; dividend = 32'd1; divisor = 32'd1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int n = 11; n <= 40; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    check("ignore_latency", lat, 32'd33);
    check("ignore_quotient", quotient, 32'd10);
    check("ignore_remainder", remainder, 32'd0);

    // asynchronous reset mid-CALC
    do_div("d10_3", 32'd10, 32'd3, 0);
    @(negedge clk);
    start = 1'b1; dividend = 32'd40; divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_quotient", quotient, 32'd0);
    check("async_remainder", remainder, 32'd0);
    check("async_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("no_done_after_abort", {31'd0, seen}, 32'd0);
    do_div("d8_3", 32'd8, 32'd3, 0);

`ifdef DIV_SIGNED_EN
    do_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 0);
    check("s_m7_2_q_const", quotient, 32'hFFFF_FFFD);
    check("s_m7_2_r_const", remainder, 32'hFFFF_FFFF);
    do_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("s_min_m1_q_const", quotient, 32'h8000_0000);
`endif

    // randomized operations, half launched back-to-back from FIN
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1, 2: b = $urandom_range(1, 255);
        3: begin a = $urandom_range(0, 1000); b = a + $urandom_range(1, 100); end
        default: b = $urandom;
      endcase
      if (b == 0 && i % 5 != 0) b = 32'd1;
      do_div($sformatf("rnd%0d", i), a, b, (i % 2) == 1);
    end

    q0 = quotient;
    repeat (5) @(negedge clk);
    check("final_hold", quotient, q0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
